triangle_setup: RTL and testbench
=================================

# triangle_setup

Pipelined triangle-setup stage between vertex fetch and the rasterizer. It accepts one screen-space triangle per cycle over a valid/ready handshake and computes three edge-function coefficient sets (A, B, C) and the doubled signed area. It also produces a screen-clamped bounding box. It drops degenerate, off-screen and mode-culled triangles, normalises winding so "inside" is always E ≥ 0, and keeps accept/cull statistics.

## Interface
- COORD_WIDTH, 16, signed two's-complement vertex coordinate width
- SCREEN_X_SIZE, 800, horizontal resolution in pixels
- SCREEN_Y_SIZE, 600, vertical resolution in pixels
- STAT_WIDTH, 32, statistics counter width
- clk  in  1  single clock; everything is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- cull_mode  in  2  0 none, 1 cull back, 2 cull front, 3 treated as none; sampled with the triangle at acceptance
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_vertexes  in  [3][3][COORD_WIDTH]  per vertex x, y, z (signed)
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_coefs  out  [3][2][COORD_WIDTH+1]  A_i, B_i signed
- out_const  out  [3][2*COORD_WIDTH+3]  C_i signed
- out_area  out  2*COORD_WIDTH+3  doubled area, always > 0
- out_bbox_min, out_bbox_max  out  [2][$clog2(max screen size)]  clamped x, y, unsigned
- out_z  out  [3][COORD_WIDTH]  z passthrough, reordered never
- stat_accepted, stat_culled  out  STAT_WIDTH  saturating counters
- busy  out  1  any pipeline stage valid

## Operation
- Edge i uses vertex i and j=(i+1)%3: A_i = y_i − y_j, B_i = x_j − x_i, C_i = −(A_i·x_i + B_i·y_i). All arithmetic is signed and sign-extended before the operation; no truncation.
- area = A_0·x_2 + B_0·y_2 + C_0. area > 0 is front-facing.
- Culled when any of these holds:
  - area = 0.
  - mode 1 and area < 0.
  - mode 2 and area > 0.
  - Unclamped bbox fully outside the screen: max_x < 0, min_x > SCREEN_X_SIZE−1, or the same test on y.
- Surviving triangles with area < 0: A, B, C and area are all negated.
- bbox: min/max of the vertex x and y, clamped to [0, SCREEN_*_SIZE−1].
- Pipeline stages:
  - S1 registers A, B, the unclamped bbox, the vertices and the mode.
  - S2 registers C and area.
  - S3 is the output register; it holds the post-cull, normalised and clamped result.
- A culled triangle leaves S2 without loading S3. stat_culled increments on that transfer cycle.
- stat_accepted increments on every in_valid && in_ready.
- Counters saturate at all-ones.

## Timing
- Reset values: out_valid=0, in_ready=1, busy=0, stat_*=0. Data outputs are 0.
- Latency: acceptance at cycle t gives out_valid at t+3 with no stall. Throughput is 1 triangle per cycle.
- Advance rules:
  - S3 loads when !out_valid || out_ready.
  - Sk loads when it is empty or stage k+1 loads.
  - in_ready = !S1_valid || S1 advances. in_ready is combinational from out_ready through the chain.
- out_valid holds and data is stable until out_ready. Order is preserved and no triangle is lost or duplicated under back-pressure.
- A culled triangle in S2 frees S2 even when S3 is stalled.
- Reset asserted mid-stream discards all in-flight triangles immediately. Counters return to 0.
- When accept and cull happen in the same cycle, both counters update independently.

## Structure
- Shared package raster_pkg holds:
  - cull_mode_e enum (CULL_NONE, CULL_BACK, CULL_FRONT).
  - Width helper functions: coef width = COORD_WIDTH+1, const width = 2*COORD_WIDTH+3, bbox width = $clog2 of the larger screen size.
- One sub-module, edge_function_unit, is instantiated three times. It is combinational in S1/S2 slices: A, B from the vertex pair, and C from A, B and the registered vertex.

## Test plan
- (0,0),(10,0),(0,10), mode 0 -> after 3 cycles the outputs are A=(0,−10,10), B=(10,−10,0), C=(0,100,0), area=100, bbox (0,0)-(10,10).
- (0,0),(0,10),(10,0) -> with mode 0, the output is negated (A=(10,−10,0)…) with area=100. With mode 1 there is no output and stat_culled=1.
- Degenerate (0,0),(5,5),(10,10) -> culled. Triangle with all x ≥ 800 -> culled.
- (−20,−20),(900,0),(0,700) -> emitted with bbox (0,0)-(799,599).
- Back-to-back stream of 6 triangles with out_ready low for cycles 2–6:
  - in_ready drops once 3 triangles are held.
  - All 6 emerge in order and stat_accepted=6.
- Reset pulse while 3 triangles are in flight -> busy=0, out_valid=0, counters 0 on the next edge. A subsequent triangle has normal 3-cycle latency.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster types and width helpers.
//   cull_mode_e  : culling selector carried down the setup pipeline
//   coef_width   : width of edge coefficients A, B
//   const_width  : width of edge constants C and of the doubled area
//   bbox_width   : width of a clamped screen coordinate
package raster_pkg;

    typedef enum logic [1:0] {
        CULL_NONE  = 2'd0,
        CULL_BACK  = 2'd1,
        CULL_FRONT = 2'd2
    } cull_mode_e;

    // A = y_i - y_j needs one bit of growth over a coordinate.
    function automatic int unsigned coef_width(input int unsigned coord_w);
        return coord_w + 1;
    endfunction

    // A*x + B*y (and the area sum) fit in 2*W+3 bits without truncation.
    function automatic int unsigned const_width(input int unsigned coord_w);
        return 2 * coord_w + 3;
    endfunction

    function automatic int unsigned bbox_width(input int unsigned sx, input int unsigned sy);
        return unsigned'($clog2((sx > sy) ? sx : sy));
    endfunction

endpackage

// File: rtl/edge_function_unit.sv
// Combinational edge-function slice for one triangle edge (vertex i -> vertex j).
// The S1 slice produces A, B from the incoming vertex pair; the S2 slice produces
// C from the registered A, B and the registered vertex i.
//   i_xi, i_yi, i_xj, i_yj : incoming vertex i and j coordinates (signed)
//   o_a, o_b               : A = y_i - y_j, B = x_j - x_i
//   i_a_r, i_b_r           : registered A, B (from S1)
//   i_xi_r, i_yi_r         : registered vertex i coordinates (from S1)
//   o_c                    : C = -(A*x_i + B*y_i)
module edge_function_unit
    import raster_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 16
) (
    input  logic signed [COORD_WIDTH-1:0]                  i_xi,
    input  logic signed [COORD_WIDTH-1:0]                  i_yi,
    input  logic signed [COORD_WIDTH-1:0]                  i_xj,
    input  logic signed [COORD_WIDTH-1:0]                  i_yj,
    output logic signed [coef_width(COORD_WIDTH)-1:0]      o_a,
    output logic signed [coef_width(COORD_WIDTH)-1:0]      o_b,
    input  logic signed [coef_width(COORD_WIDTH)-1:0]      i_a_r,
    input  logic signed [coef_width(COORD_WIDTH)-1:0]      i_b_r,
    input  logic signed [COORD_WIDTH-1:0]                  i_xi_r,
    input  logic signed [COORD_WIDTH-1:0]                  i_yi_r,
    output logic signed [const_width(COORD_WIDTH)-1:0]     o_c
);

    localparam int unsigned CFW = coef_width(COORD_WIDTH);
    localparam int unsigned KW  = const_width(COORD_WIDTH);

    // Operands are sign-extended to the result width before any arithmetic.
    assign o_a = CFW'(i_yi) - CFW'(i_yj);
    assign o_b = CFW'(i_xj) - CFW'(i_xi);
    assign o_c = -((KW'(i_a_r) * KW'(i_xi_r)) + (KW'(i_b_r) * KW'(i_yi_r)));

endmodule

// File: rtl/triangle_setup.sv
// Three-stage triangle setup: edge coefficients, doubled area, culling,
// winding normalisation and screen-clamped bounding box.
//   clk, reset                 : clock, asynchronous active-high reset
//   cull_mode                  : 0 none, 1 back, 2 front, 3 none
//   in_valid/in_ready          : input handshake, in_vertexes[v][x,y,z]
//   out_valid/out_ready        : output handshake
//   out_coefs[e][A,B], out_const[e], out_area : normalised edge equations
//   out_bbox_min/max[x,y]      : clamped bounding box
//   out_z                      : vertex z passthrough
//   stat_accepted, stat_culled : saturating statistics
//   busy                       : any stage holds a triangle
module triangle_setup
    import raster_pkg::*;
#(
    parameter int unsigned COORD_WIDTH   = 16,
    parameter int unsigned SCREEN_X_SIZE = 800,
    parameter int unsigned SCREEN_Y_SIZE = 600,
    parameter int unsigned STAT_WIDTH    = 32
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [1:0]                                                   cull_mode,
    input  logic                                                         in_valid,
    output logic                                                         in_ready,
    input  logic [2:0][2:0][COORD_WIDTH-1:0]                             in_vertexes,
    output logic                                                         out_valid,
    input  logic                                                         out_ready,
    output logic [2:0][1:0][coef_width(COORD_WIDTH)-1:0]                 out_coefs,
    output logic [2:0][const_width(COORD_WIDTH)-1:0]                     out_const,
    output logic [const_width(COORD_WIDTH)-1:0]                          out_area,
    output logic [1:0][bbox_width(SCREEN_X_SIZE, SCREEN_Y_SIZE)-1:0]     out_bbox_min,
    output logic [1:0][bbox_width(SCREEN_X_SIZE, SCREEN_Y_SIZE)-1:0]     out_bbox_max,
    output logic [2:0][COORD_WIDTH-1:0]                                  out_z,
    output logic [STAT_WIDTH-1:0]                                        stat_accepted,
    output logic [STAT_WIDTH-1:0]                                        stat_culled,
    output logic                                                         busy
);

    localparam int unsigned CW  = COORD_WIDTH;
    localparam int unsigned CFW = coef_width(COORD_WIDTH);
    localparam int unsigned KW  = const_width(COORD_WIDTH);
    localparam int unsigned BW  = bbox_width(SCREEN_X_SIZE, SCREEN_Y_SIZE);

    localparam logic signed [CW-1:0] X_HI = CW'(SCREEN_X_SIZE - 1);
    localparam logic signed [CW-1:0] Y_HI = CW'(SCREEN_Y_SIZE - 1);

    function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] p,
                                                  input logic signed [CW-1:0] q,
                                                  input logic signed [CW-1:0] r);
        logic signed [CW-1:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] p,
                                                  input logic signed [CW-1:0] q,
                                                  input logic signed [CW-1:0] r);
        logic signed [CW-1:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    function automatic logic [BW-1:0] clamp_coord(input logic signed [CW-1:0] v,
                                                  input logic signed [CW-1:0] hi);
        logic [BW-1:0] r;
        if (v[CW-1]) begin
            r = '0;
        end else if (v > hi) begin
            r = BW'(hi);
        end else begin
            r = BW'(v);
        end
        return r;
    endfunction

    // Incoming vertex unpack and mode decode
    logic signed [CW-1:0]  w_in_x [3];
    logic signed [CW-1:0]  w_in_y [3];
    logic signed [CW-1:0]  w_in_z [3];
    cull_mode_e            w_in_mode;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_in_x[k] = in_vertexes[k][0];
            w_in_y[k] = in_vertexes[k][1];
            w_in_z[k] = in_vertexes[k][2];
        end
        w_in_mode = CULL_NONE;
        if (cull_mode == 2'd1) begin
            w_in_mode = CULL_BACK;
        end else if (cull_mode == 2'd2) begin
            w_in_mode = CULL_FRONT;
        end
    end

    // Stage 1 state
    logic                  r_s1_valid;
    logic signed [CW-1:0]  r_s1_x [3];
    logic signed [CW-1:0]  r_s1_y [3];
    logic signed [CW-1:0]  r_s1_z [3];
    logic signed [CFW-1:0] r_s1_a [3];
    logic signed [CFW-1:0] r_s1_b [3];
    logic signed [CW-1:0]  r_s1_min_x, r_s1_max_x, r_s1_min_y, r_s1_max_y;
    cull_mode_e            r_s1_mode;

    // Stage 2 state
    logic                  r_s2_valid;
    logic signed [CFW-1:0] r_s2_a [3];
    logic signed [CFW-1:0] r_s2_b [3];
    logic signed [KW-1:0]  r_s2_c [3];
    logic signed [KW-1:0]  r_s2_area;
    logic signed [CW-1:0]  r_s2_z [3];
    logic signed [CW-1:0]  r_s2_min_x, r_s2_max_x, r_s2_min_y, r_s2_max_y;
    cull_mode_e            r_s2_mode;

    // Stage 3 (output) state
    logic                  r_s3_valid;
    logic signed [CFW-1:0] r_s3_a [3];
    logic signed [CFW-1:0] r_s3_b [3];
    logic signed [KW-1:0]  r_s3_c [3];
    logic signed [KW-1:0]  r_s3_area;
    logic signed [CW-1:0]  r_s3_z [3];
    logic [BW-1:0]         r_s3_min_x, r_s3_max_x, r_s3_min_y, r_s3_max_y;

    logic [STAT_WIDTH-1:0] r_stat_acc;
    logic [STAT_WIDTH-1:0] r_stat_cull;

    // Edge units: A/B from the input vertices, C from the S1 registers
    logic signed [CFW-1:0] w_a [3];
    logic signed [CFW-1:0] w_b [3];
    logic signed [KW-1:0]  w_c [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        edge_function_unit #(
            .COORD_WIDTH (CW)
        ) u_edge (
            .i_xi   (w_in_x[gi]),
            .i_yi   (w_in_y[gi]),
            .i_xj   (w_in_x[(gi + 1) % 3]),
            .i_yj   (w_in_y[(gi + 1) % 3]),
            .o_a    (w_a[gi]),
            .o_b    (w_b[gi]),
            .i_a_r  (r_s1_a[gi]),
            .i_b_r  (r_s1_b[gi]),
            .i_xi_r (r_s1_x[gi]),
            .i_yi_r (r_s1_y[gi]),
            .o_c    (w_c[gi])
        );
    end

    // Doubled signed area: edge 0 evaluated at vertex 2
    logic signed [KW-1:0] w_area;
    assign w_area = (KW'(r_s1_a[0]) * KW'(r_s1_x[2]))
                  + (KW'(r_s1_b[0]) * KW'(r_s1_y[2]))
                  + w_c[0];

    // Cull decision on the S2 contents
    logic w_s2_neg, w_s2_zero, w_s2_off, w_s2_cull;
    assign w_s2_neg  = r_s2_area[KW-1];
    assign w_s2_zero = (r_s2_area == '0);
    assign w_s2_off  = r_s2_max_x[CW-1] || r_s2_max_y[CW-1]
                    || (r_s2_min_x > X_HI) || (r_s2_min_y > Y_HI);
    assign w_s2_cull = w_s2_zero
                    || ((r_s2_mode == CULL_BACK)  && w_s2_neg)
                    || ((r_s2_mode == CULL_FRONT) && !w_s2_neg)
                    || w_s2_off;

    // Advance chain; a culled S2 entry drains even while S3 is stalled
    logic w_s3_load, w_s2_free, w_s1_load, w_accept, w_s2_fwd, w_cull_evt;
    assign w_s3_load  = !r_s3_valid || out_ready;
    assign w_s2_free  = !r_s2_valid || w_s3_load || w_s2_cull;
    assign w_s1_load  = !r_s1_valid || w_s2_free;
    assign w_accept   = in_valid && w_s1_load;
    assign w_s2_fwd   = r_s2_valid && !w_s2_cull;
    assign w_cull_evt = r_s2_valid && w_s2_cull;

    // Stage 1: A, B, raw bbox, vertices, mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= CULL_NONE;
            r_s1_min_x <= '0;
            r_s1_max_x <= '0;
            r_s1_min_y <= '0;
            r_s1_max_y <= '0;
            for (int k = 0; k < 3; k++) begin
                r_s1_x[k] <= '0;
                r_s1_y[k] <= '0;
                r_s1_z[k] <= '0;
                r_s1_a[k] <= '0;
                r_s1_b[k] <= '0;
            end
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode  <= w_in_mode;
                r_s1_min_x <= min3(w_in_x[0], w_in_x[1], w_in_x[2]);
                r_s1_max_x <= max3(w_in_x[0], w_in_x[1], w_in_x[2]);
                r_s1_min_y <= min3(w_in_y[0], w_in_y[1], w_in_y[2]);
                r_s1_max_y <= max3(w_in_y[0], w_in_y[1], w_in_y[2]);
                for (int k = 0; k < 3; k++) begin
                    r_s1_x[k] <= w_in_x[k];
                    r_s1_y[k] <= w_in_y[k];
                    r_s1_z[k] <= w_in_z[k];
                    r_s1_a[k] <= w_a[k];
                    r_s1_b[k] <= w_b[k];
                end
            end
        end
    end

    // Stage 2: C and area
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= CULL_NONE;
            r_s2_area  <= '0;
            r_s2_min_x <= '0;
            r_s2_max_x <= '0;
            r_s2_min_y <= '0;
            r_s2_max_y <= '0;
            for (int k = 0; k < 3; k++) begin
                r_s2_a[k] <= '0;
                r_s2_b[k] <= '0;
                r_s2_c[k] <= '0;
                r_s2_z[k] <= '0;
            end
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode  <= r_s1_mode;
                r_s2_area  <= w_area;
                r_s2_min_x <= r_s1_min_x;
                r_s2_max_x <= r_s1_max_x;
                r_s2_min_y <= r_s1_min_y;
                r_s2_max_y <= r_s1_max_y;
                for (int k = 0; k < 3; k++) begin
                    r_s2_a[k] <= r_s1_a[k];
                    r_s2_b[k] <= r_s1_b[k];
                    r_s2_c[k] <= w_c[k];
                    r_s2_z[k] <= r_s1_z[k];
                end
            end
        end
    end

    // Stage 3: surviving triangles, winding flipped so inside is E >= 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
            r_s3_area  <= '0;
            r_s3_min_x <= '0;
            r_s3_max_x <= '0;
            r_s3_min_y <= '0;
            r_s3_max_y <= '0;
            for (int k = 0; k < 3; k++) begin
                r_s3_a[k] <= '0;
                r_s3_b[k] <= '0;
                r_s3_c[k] <= '0;
                r_s3_z[k] <= '0;
            end
        end else if (w_s3_load) begin
            r_s3_valid <= w_s2_fwd;
            if (w_s2_fwd) begin
                r_s3_area  <= w_s2_neg ? -r_s2_area : r_s2_area;
                r_s3_min_x <= clamp_coord(r_s2_min_x, X_HI);
                r_s3_max_x <= clamp_coord(r_s2_max_x, X_HI);
                r_s3_min_y <= clamp_coord(r_s2_min_y, Y_HI);
                r_s3_max_y <= clamp_coord(r_s2_max_y, Y_HI);
                for (int k = 0; k < 3; k++) begin
                    r_s3_a[k] <= w_s2_neg ? -r_s2_a[k] : r_s2_a[k];
                    r_s3_b[k] <= w_s2_neg ? -r_s2_b[k] : r_s2_b[k];
                    r_s3_c[k] <= w_s2_neg ? -r_s2_c[k] : r_s2_c[k];
                    r_s3_z[k] <= r_s2_z[k];
                end
            end
        end
    end

    // Saturating statistics; both may step in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_acc  <= '0;
            r_stat_cull <= '0;
        end else begin
            if (w_accept && (r_stat_acc != '1)) begin
                r_stat_acc <= r_stat_acc + STAT_WIDTH'(1);
            end
            if (w_cull_evt && (r_stat_cull != '1)) begin
                r_stat_cull <= r_stat_cull + STAT_WIDTH'(1);
            end
        end
    end

    // Output mapping
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            out_coefs[k][0] = r_s3_a[k];
            out_coefs[k][1] = r_s3_b[k];
            out_const[k]    = r_s3_c[k];
            out_z[k]        = r_s3_z[k];
        end
    end

    assign out_area        = r_s3_area;
    assign out_bbox_min[0] = r_s3_min_x;
    assign out_bbox_min[1] = r_s3_min_y;
    assign out_bbox_max[0] = r_s3_max_x;
    assign out_bbox_max[1] = r_s3_max_y;
    assign out_valid       = r_s3_valid;
    assign in_ready        = w_s1_load;
    assign busy            = r_s1_valid || r_s2_valid || r_s3_valid;
    assign stat_accepted   = r_stat_acc;
    assign stat_culled     = r_stat_cull;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: table of hand-computed triangles, a
// back-pressured stream and a mid-stream reset.
module tb_triangle_setup;

    logic                     clk;
    logic                     reset;
    logic [1:0]               cull_mode;
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0][2:0][15:0]    in_vertexes;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0][1:0][16:0]    out_coefs;
    logic [2:0][34:0]         out_const;
    logic [34:0]              out_area;
    logic [1:0][9:0]          out_bbox_min;
    logic [1:0][9:0]          out_bbox_max;
    logic [2:0][15:0]         out_z;
    logic [31:0]              stat_accepted;
    logic [31:0]              stat_culled;
    logic                     busy;

    triangle_setup dut (
        .clk           (clk),
        .reset         (reset),
        .cull_mode     (cull_mode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vertexes   (in_vertexes),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_coefs     (out_coefs),
        .out_const     (out_const),
        .out_area      (out_area),
        .out_bbox_min  (out_bbox_min),
        .out_bbox_max  (out_bbox_max),
        .out_z         (out_z),
        .stat_accepted (stat_accepted),
        .stat_culled   (stat_culled),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][15:0] vx;
        logic [2:0][15:0] vy;
        logic [2:0][15:0] vz;
        logic [1:0]       mode;
        logic             emit;
        logic [2:0][16:0] a;
        logic [2:0][16:0] b;
        logic [2:0][34:0] c;
        logic [34:0]      area;
        logic [1:0][9:0]  bmin;
        logic [1:0][9:0]  bmax;
    } vec_t;

    vec_t tbl [12];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_acc  = 0;
    int   exp_cull = 0;

    function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int md, input bit em,
                                input int a0, input int a1, input int a2,
                                input int b0, input int b1, input int b2,
                                input longint c0, input longint c1, input longint c2,
                                input longint ar, input int mnx, input int mny,
                                input int mxx, input int mxy);
        vec_t v;
        v = '0;
        v.vx[0] = 16'(x0); v.vy[0] = 16'(y0);
        v.vx[1] = 16'(x1); v.vy[1] = 16'(y1);
        v.vx[2] = 16'(x2); v.vy[2] = 16'(y2);
        v.mode  = 2'(md);
        v.emit  = em;
        v.a[0] = 17'(a0); v.a[1] = 17'(a1); v.a[2] = 17'(a2);
        v.b[0] = 17'(b0); v.b[1] = 17'(b1); v.b[2] = 17'(b2);
        v.c[0] = 35'(c0); v.c[1] = 35'(c1); v.c[2] = 35'(c2);
        v.area = 35'(ar);
        v.bmin[0] = 10'(mnx); v.bmin[1] = 10'(mny);
        v.bmax[0] = 10'(mxx); v.bmax[1] = 10'(mxy);
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_tri(input vec_t v);
        for (int k = 0; k < 3; k++) begin
            in_vertexes[k][0] = v.vx[k];
            in_vertexes[k][1] = v.vy[k];
            in_vertexes[k][2] = v.vz[k];
        end
        cull_mode = v.mode;
    endtask

    task automatic check_out(input vec_t v, input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s A%0d", tag, k), $signed(out_coefs[k][0]), $signed(v.a[k]));
            chk($sformatf("%s B%0d", tag, k), $signed(out_coefs[k][1]), $signed(v.b[k]));
            chk($sformatf("%s C%0d", tag, k), $signed(out_const[k]), $signed(v.c[k]));
            chk($sformatf("%s z%0d", tag, k), $signed(out_z[k]), $signed(v.vz[k]));
        end
        chk({tag, " area"}, $signed(out_area), $signed(v.area));
        chk({tag, " bbox min x"}, longint'(out_bbox_min[0]), longint'(v.bmin[0]));
        chk({tag, " bbox min y"}, longint'(out_bbox_min[1]), longint'(v.bmin[1]));
        chk({tag, " bbox max x"}, longint'(out_bbox_max[0]), longint'(v.bmax[0]));
        chk({tag, " bbox max y"}, longint'(out_bbox_max[1]), longint'(v.bmax[1]));
    endtask

    // One isolated triangle; entry and exit at posedge+1
    task automatic run_vec(input int idx, input string tag);
        int lat;
        bit seen;
        vec_t v;
        v = tbl[idx];
        @(posedge clk); #1;
        drive_tri(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " in_ready"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_acc++;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (v.emit) begin
            chk({tag, " latency"}, seen ? lat : -1, 3);
            if (seen) check_out(v, tag);
        end else begin
            chk({tag, " culled no output"}, longint'(seen), 0);
            exp_cull++;
        end
        chk({tag, " stat_accepted"}, longint'(stat_accepted), exp_acc);
        chk({tag, " stat_culled"}, longint'(stat_culled), exp_cull);
    endtask

    int sidx [6];
    int sent;
    int recv;

    initial begin
        //            x0  y0  x1  y1  x2  y2 md em   A0   A1   A2   B0   B1   B2     C0      C1     C2    area  bbox
        tbl[0]  = mk(  0,  0, 10,  0,  0, 10, 0, 1,    0, -10,  10,  10, -10,   0,     0,    100,     0,   100,  0,  0,  10,  10);
        tbl[1]  = mk(  0,  0,  0, 10, 10,  0, 0, 1,   10, -10,   0,   0, -10,  10,     0,    100,     0,   100,  0,  0,  10,  10);
        tbl[2]  = mk(  0,  0,  0, 10, 10,  0, 1, 0,    0,   0,   0,   0,   0,   0,     0,      0,     0,     0,  0,  0,   0,   0);
        tbl[3]  = mk(  0,  0,  0, 10, 10,  0, 2, 1,   10, -10,   0,   0, -10,  10,     0,    100,     0,   100,  0,  0,  10,  10);
        tbl[4]  = mk(  0,  0, 10,  0,  0, 10, 2, 0,    0,   0,   0,   0,   0,   0,     0,      0,     0,     0,  0,  0,   0,   0);
        tbl[5]  = mk(  0,  0, 10,  0,  0, 10, 1, 1,    0, -10,  10,  10, -10,   0,     0,    100,     0,   100,  0,  0,  10,  10);
        tbl[6]  = mk(  0,  0,  0, 10, 10,  0, 3, 1,   10, -10,   0,   0, -10,  10,     0,    100,     0,   100,  0,  0,  10,  10);
        tbl[7]  = mk(  0,  0,  5,  5, 10, 10, 0, 0,    0,   0,   0,   0,   0,   0,     0,      0,     0,     0,  0,  0,   0,   0);
        tbl[8]  = mk(800,  0,900,  0,800,100, 0, 0,    0,   0,   0,   0,   0,   0,     0,      0,     0,     0,  0,  0,   0,   0);
        tbl[9]  = mk(-20,-20,900,  0,  0,700, 0, 1,  -20,-700, 720, 920,-900, -20, 18000, 630000, 14000,662000,  0,  0, 799, 599);
        tbl[10] = mk(-30, -5,-10, -5,-20, 10, 0, 0,    0,   0,   0,   0,   0,   0,     0,      0,     0,     0,  0,  0,   0,   0);
        tbl[11] = mk(790,590,810,590,790,610, 0, 1,    0, -20,  20,  20, -20,   0,-11800,  28000,-15800,   400,790,590, 799, 599);
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 3; k++) tbl[i].vz[k] = 16'(100 * i + k - 7);
        end
        sidx[0] = 0; sidx[1] = 1; sidx[2] = 9; sidx[3] = 11; sidx[4] = 5; sidx[5] = 6;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        cull_mode   = 2'd0;
        in_vertexes = '0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset in_ready", longint'(in_ready), 1);
        chk("reset busy", longint'(busy), 0);
        chk("reset stat_accepted", longint'(stat_accepted), 0);
        chk("reset stat_culled", longint'(stat_culled), 0);
        chk("reset out_area", longint'(out_area), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, $sformatf("vec%0d", i));

        // Back-to-back stream with out_ready low in cycles 2..6
        sent = 0;
        recv = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 60 && recv < 6; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            if (sent < 6) begin
                drive_tri(tbl[sidx[sent]]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) chk("stream in_ready one held", longint'(in_ready), 1);
            if (c == 4) chk("stream in_ready three held", longint'(in_ready), 0);
            if (c == 5) chk("stream busy", longint'(busy), 1);
            if (out_valid && recv < 6) begin
                if (!out_ready) begin
                    chk($sformatf("stream hold%0d area", recv), $signed(out_area),
                        $signed(tbl[sidx[recv]].area));
                end else begin
                    check_out(tbl[sidx[recv]], $sformatf("stream%0d", recv));
                    recv++;
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        exp_acc += 6;
        chk("stream received", recv, 6);
        chk("stream sent", sent, 6);
        chk("stream stat_accepted", longint'(stat_accepted), exp_acc);
        chk("stream stat_culled", longint'(stat_culled), exp_cull);

        // Reset with three triangles in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_tri(tbl[sidx[k]]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight busy", longint'(busy), 1);
        chk("inflight out_valid", longint'(out_valid), 1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset busy", longint'(busy), 0);
        chk("midreset out_valid", longint'(out_valid), 0);
        chk("midreset in_ready", longint'(in_ready), 1);
        chk("midreset stat_accepted", longint'(stat_accepted), 0);
        chk("midreset stat_culled", longint'(stat_culled), 0);
        reset    = 1'b0;
        exp_acc  = 0;
        exp_cull = 0;
        run_vec(9, "postreset");
        run_vec(7, "postreset degenerate");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
